v65_alu_seq: RTL
================

Name: v65_alu_seq

Overview:
- Program sequencer that drives the 4-bit accumulator ALU (opcode/operand in; q and cf/zf/nf back). It is the initiator side of the ALU interface.
- Holds a 16x8 program memory, loaded while idle. On start it clears the accumulator, then runs one instruction per clock: ALU op, conditional branch on flags, store result, or halt.
- Raises done/err at the end of the run.

Parameters:
- MAX_STEPS, 255, maximum instructions executed in RUN before abort. The step counter is 8 bits.

Ports:
- c  in  1  clock; all state updates on posedge c
- rn  in  1  asynchronous active-low reset
- start  in  1  begin run; sampled in IDLE only
- we  in  1  program memory write strobe; honoured in IDLE only
- wa  in  4  program write address
- wd  in  8  program write data
- k  out  2  ALU opcode: 00 add, 01 or, 10 and, 11 xor
- d  out  4  ALU operand
- q_in  in  4  ALU accumulator
- cf_in, zf_in, nf_in  in  1 each  ALU flags
- res  out  4  stored result
- res_valid  out  1  one-cycle pulse when res is updated
- busy  out  1  high in INIT and RUN
- done  out  1  one-cycle pulse at end of run
- err  out  1  step limit hit; held until next start
- pc  out  4  program counter

Behaviour:
- Reset (async, rn=0): state IDLE, pc=0, step=0, res=0, res_valid=0, done=0, err=0. Program memory is not cleared.
- The ALU has no enable and updates on every edge. k/d are therefore combinational from state and mem[pc]. Every non-ALU-op cycle drives the HOLD op (k=01, d=0): q is unchanged, zf/nf are recomputed, cf is cleared.
- Instruction mem[pc][7:0]:
  - [7:6]=00 ALU op: k=[5:4], d=[3:0]; pc+1.
  - [7:6]=01 branch: cond [5:4] is 00 always, 01 zf_in, 10 nf_in, 11 cf_in. Flags are sampled in this cycle. If taken, pc=[3:0]; else pc+1. Drives HOLD.
  - [7:6]=10 STORE: res<=q_in, res_valid=1 for the next cycle. Drives HOLD.
  - [7:6]=11 HALT: drives HOLD; go to DONE.
- Flags seen by an instruction are those produced by the previous cycle's ALU edge. A carry branch must directly follow the ALU op: any intervening non-ALU cycle clears cf.
- State machine:
  - IDLE: drives HOLD. If start=1, go to INIT, pc<=0, step<=0, err<=0.
  - INIT: one cycle driving k=10, d=0, which clears q to 0 at the edge. Go to RUN.
  - RUN: executes mem[pc]; step+1 each cycle. If step reaches MAX_STEPS-1 and the instruction is not HALT, execute it, then go to DONE with err<=1.
  - DONE: done=1 for one cycle, then IDLE.
- pc wraps 15 to 0 on +1.
- we in IDLE writes mem[wa]<=wd at the edge. we or start in any other state is ignored.
- start with we in the same IDLE cycle: the write completes and the run starts. The write lands before INIT, so it is visible to the run.
- Reset mid-run returns to IDLE immediately. ALU q is left as-is; the next run's INIT clears it.
- Latency: done appears N+2 cycles after start is sampled, where N is the number of RUN instructions including HALT.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ADD=00, OR=01, AND=10, XOR=11.
  - Instruction class codes.
  - Branch condition codes.
  - State encoding: IDLE, INIT, RUN, DONE.
- Sub-module v65_prog_mem (16x8, sync write, async read) is natural.
- The bench instantiates v65_alu_seq together with the ALU.

Test Plan:
- Program {05,03,80,C0}, start → q goes 0,5,8; res=8 with one res_valid pulse, nf_in=1 at store; done 6 cycles after start; err=0.
- Program {0F,01,75,C0,C0,80,C0} → 15+1 gives q=0, cf=1, zf=1; branch taken to 5; res=0; done; addresses 3/4 never executed (watch pc).
- Program {03,54,80,C0} → zf=0, branch not taken; res=3; pc sequence 0,1,2,3.
- Program {0A,26,35,80,C0} → q 10, then 2 (AND 6), then 7 (XOR 5); res=7.
- MAX_STEPS=8, program {40} (branch always to 0) → exactly 8 RUN cycles, then done with err=1; res_valid never asserted.
- Assert rn low during RUN → busy=0, done=0, res unchanged (0 after reset); we and start pulsed during RUN are ignored; memory contents survive reset and re-run gives identical res.

Source files
------------

// File: rtl/v65_alu_seq_pkg.sv
// Shared definitions for the v65 ALU program sequencer: ALU opcodes,
// instruction classes, branch conditions and sequencer state encoding.
package v65_alu_seq_pkg;

  // ALU opcodes driven on k
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Instruction class, taken from instr[7:6]
  typedef enum logic [1:0] {
    CLS_ALU   = 2'b00,
    CLS_BR    = 2'b01,
    CLS_STORE = 2'b10,
    CLS_HALT  = 2'b11
  } instr_cls_e;

  // Branch condition, taken from instr[5:4]
  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_ZF     = 2'b01,
    COND_NF     = 2'b10,
    COND_CF     = 2'b11
  } br_cond_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_INIT = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Sequential program counter advance; wraps 15 -> 0 naturally
  function automatic logic [3:0] pc_inc(input logic [3:0] pc_cur);
    return pc_cur + 4'd1;
  endfunction

endpackage

// File: rtl/v65_alu_seq_prog.sv
// 16x8 program memory: synchronous write, asynchronous read.
// Contents are deliberately not reset so a program survives rn.
module v65_alu_seq_prog
  import v65_alu_seq_pkg::*;
(
  input  logic       c,
  input  logic       we,
  input  logic [3:0] wa,
  input  logic [7:0] wd,
  input  logic [3:0] ra,
  output logic [7:0] rd
);

  logic [7:0] mem_r [16];

  // Write port: store wd at wa on a qualified strobe
  always_ff @(posedge c) begin
    if (we) begin
      mem_r[wa] <= wd;
    end
  end

  assign rd = mem_r[ra];

endmodule

// File: rtl/v65_alu_seq.sv
// Program sequencer driving the 4-bit accumulator ALU. Loads a 16-word
// program while idle, clears the accumulator, runs one instruction per
// clock and reports done/err. k/d are combinational because the ALU
// updates on every edge; all status outputs are registered.
module v65_alu_seq
  import v65_alu_seq_pkg::*;
#(
  parameter int MAX_STEPS = 255
) (
  input  logic       c,
  input  logic       rn,
  input  logic       start,
  input  logic       we,
  input  logic [3:0] wa,
  input  logic [7:0] wd,
  output logic [1:0] k,
  output logic [3:0] d,
  input  logic [3:0] q_in,
  input  logic       cf_in,
  input  logic       zf_in,
  input  logic       nf_in,
  output logic [3:0] res,
  output logic       res_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] pc
);

  localparam logic [7:0] LAST_STEP = 8'(MAX_STEPS - 1);

  state_e     state_r;
  logic [3:0] pc_r;
  logic [7:0] step_r;
  logic [3:0] res_r;
  logic       res_valid_r;
  logic       busy_r;
  logic       done_r;
  logic       err_r;

  logic [7:0] instr_s;
  logic       mem_we_s;
  instr_cls_e cls_s;
  logic       taken_s;

  // Program writes are only honoured while idle
  assign mem_we_s = we && (state_r == ST_IDLE);

  v65_alu_seq_prog u_prog (
    .c  (c),
    .we (mem_we_s),
    .wa (wa),
    .wd (wd),
    .ra (pc_r),
    .rd (instr_s)
  );

  assign cls_s = instr_cls_e'(instr_s[7:6]);

  // Branch condition evaluation on flags from the previous ALU edge
  always_comb begin
    taken_s = 1'b0;
    case (br_cond_e'(instr_s[5:4]))
      COND_ALWAYS: taken_s = 1'b1;
      COND_ZF:     taken_s = zf_in;
      COND_NF:     taken_s = nf_in;
      COND_CF:     taken_s = cf_in;
      default:     taken_s = 1'b0;
    endcase
  end

  // ALU drive: INIT clears q, RUN ALU ops pass through, all else holds
  always_comb begin
    k = ALU_OR;
    d = 4'd0;
    case (state_r)
      ST_INIT: begin
        k = ALU_AND;
        d = 4'd0;
      end
      ST_RUN: begin
        if (cls_s == CLS_ALU) begin
          k = instr_s[5:4];
          d = instr_s[3:0];
        end else begin
          k = ALU_OR;
          d = 4'd0;
        end
      end
      default: begin
        k = ALU_OR;
        d = 4'd0;
      end
    endcase
  end

  // Sequencer FSM with registered status outputs
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state_r     <= ST_IDLE;
      pc_r        <= 4'd0;
      step_r      <= 8'd0;
      res_r       <= 4'd0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      res_valid_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_INIT;
            pc_r    <= 4'd0;
            step_r  <= 8'd0;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_INIT: begin
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          step_r <= step_r + 8'd1;
          case (cls_s)
            CLS_ALU: pc_r <= pc_inc(pc_r);
            CLS_BR:  pc_r <= taken_s ? instr_s[3:0] : pc_inc(pc_r);
            CLS_STORE: begin
              res_r       <= q_in;
              res_valid_r <= 1'b1;
              pc_r        <= pc_inc(pc_r);
            end
            default: pc_r <= pc_r;
          endcase
          if (cls_s == CLS_HALT) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (step_r == LAST_STEP) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            err_r   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = pc_r;
  assign res       = res_r;
  assign res_valid = res_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule
